// File: rtl/mac_sequencer.sv
// Control sequencer for the MAC datapath: streams N operand pairs into the operand register,
// handshakes the multiplier and steers the accumulator, then pulses done.
module mac_sequencer #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] n_terms,
    input  logic       abort,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       ldu,
    output logic       ldd,
    output logic       mult_start,
    input  logic       mult_done,
    output logic       acc_clr,
    output logic       acc_en,
    output logic [3:0] term_idx,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [2:0] {
        StIdle,
        StClr,
        StLdX,
        StLdY,
        StMul,
        StWait,
        StAcc,
        StDone
    } state_e;

    localparam logic [3:0] TimeoutLast = 4'(TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [3:0] term_idx_q, term_idx_d;
    logic [3:0] timer_q, timer_d;
    logic [3:0] n_q, n_d;
    logic       err_q, err_d;
    logic       last_term;

    // Widened so the +1 cannot wrap back onto a small N.
    assign last_term = ({1'b0, term_idx_q} + 5'd1) == {1'b0, n_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            term_idx_q <= 4'd0;
            timer_q    <= 4'd0;
            n_q        <= 4'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            term_idx_q <= term_idx_d;
            timer_q    <= timer_d;
            n_q        <= n_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        term_idx_d = term_idx_q;
        timer_d    = timer_q;
        n_d        = n_q;
        err_d      = err_q;
        in_ready   = 1'b0;
        ldu        = 1'b0;
        ldd        = 1'b0;
        mult_start = 1'b0;
        acc_clr    = 1'b0;
        acc_en     = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    n_d     = n_terms;
                    err_d   = 1'b0;
                    state_d = (n_terms == 4'd0) ? StDone : StClr;
                end
            end
            StClr: begin
                acc_clr    = 1'b1;
                term_idx_d = 4'd0;
                state_d    = StLdX;
            end
            StLdX: begin
                in_ready = 1'b1;
                ldu      = in_valid;
                if (in_valid) state_d = StLdY;
            end
            StLdY: begin
                in_ready = 1'b1;
                ldd      = in_valid;
                if (in_valid) state_d = StMul;
            end
            StMul: begin
                mult_start = 1'b1;
                timer_d    = 4'd0;
                state_d    = StWait;
            end
            StWait: begin
                // A result arriving in the final allowed cycle beats the timeout.
                if (mult_done) begin
                    state_d = StAcc;
                end else if (timer_q == TimeoutLast) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + 4'd1;
                end
            end
            StAcc: begin
                acc_en = 1'b1;
                if (last_term) begin
                    state_d = StDone;
                end else begin
                    term_idx_d = term_idx_q + 4'd1;
                    state_d    = StLdX;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
        endcase

        // Abort overrides every transition and freezes the bookkeeping registers.
        if (abort && (state_q != StIdle)) begin
            state_d    = StIdle;
            term_idx_d = term_idx_q;
            timer_d    = timer_q;
            err_d      = err_q;
        end
    end

    assign busy     = (state_q != StIdle);
    assign term_idx = term_idx_q;
    assign err      = err_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a behavioural block-level model.
module tb_mac_sequencer;

    localparam int unsigned TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] n_terms;
    logic       abort;
    logic       in_valid;
    logic       in_ready;
    logic       ldu;
    logic       ldd;
    logic       mult_start;
    logic       mult_done;
    logic       acc_clr;
    logic       acc_en;
    logic [3:0] term_idx;
    logic       busy;
    logic       done;
    logic       err;

    int tests = 0;
    int fails = 0;

    mac_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .n_terms   (n_terms),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ldu       (ldu),
        .ldd       (ldd),
        .mult_start(mult_start),
        .mult_done (mult_done),
        .acc_clr   (acc_clr),
        .acc_en    (acc_en),
        .term_idx  (term_idx),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] dut_vec();
        return {in_ready, ldu, ldd, mult_start, acc_clr, acc_en, busy, done, err, term_idx};
    endfunction

    function automatic logic [7:0] pulse_vec();
        return {busy, acc_clr, ldu, ldd, mult_start, acc_en, done, err};
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        tests++;
        if (act != expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Behavioural model: block in progress, which pair, which step of the pair, WAIT count.
    bit m_active, m_clr, m_fin, m_err;
    int m_n, m_k, m_sub, m_wait;

    always @(negedge clk) begin
        logic [12:0] e_vec;
        bit pair;
        if (!rst) begin
            m_active = 0; m_clr = 0; m_fin = 0; m_err = 0;
            m_n = 0; m_k = 0; m_sub = 0; m_wait = 0;
            chk("reset_outputs", dut_vec(), 0);
        end else begin
            pair  = m_active && !m_clr && !m_fin;
            e_vec = {pair && m_sub <= 1, pair && m_sub == 0 && in_valid,
                     pair && m_sub == 1 && in_valid, pair && m_sub == 2,
                     m_active && m_clr, pair && m_sub == 4, m_active, m_fin, m_err, 4'(m_k)};
            chk("cycle_outputs", dut_vec(), e_vec);
            if (!m_active) begin
                if (start) begin
                    m_n = n_terms; m_err = 0; m_active = 1;
                    if (m_n == 0) m_fin = 1;
                    else m_clr = 1;
                end
            end else if (abort) begin
                m_active = 0; m_clr = 0; m_fin = 0; m_sub = 0;
            end else if (m_fin) begin
                m_active = 0; m_fin = 0; m_sub = 0;
            end else if (m_clr) begin
                m_clr = 0; m_k = 0; m_sub = 0;
            end else begin
                case (m_sub)
                    0: if (in_valid) m_sub = 1;
                    1: if (in_valid) m_sub = 2;
                    2: begin m_sub = 3; m_wait = 0; end
                    3: begin
                        m_wait++;
                        if (mult_done) m_sub = 4;
                        else if (m_wait == TIMEOUT) begin
                            m_err = 1; m_active = 0; m_sub = 0;
                        end
                    end
                    default: begin
                        if (m_k + 1 == m_n) m_fin = 1;
                        else begin m_k++; m_sub = 0; end
                    end
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        start = 0; abort = 0; in_valid = 0; mult_done = 0; n_terms = 0;
    endtask

    task automatic begin_block(input int n);
        tick();
        quiet();
        start = 1; n_terms = 4'(n); in_valid = 1;
    endtask

    logic [7:0] t1 [1:8] = '{8'hC0, 8'hA0, 8'h90, 8'h88, 8'h80, 8'h84, 8'h82, 8'h00};

    initial begin
        int na, done_c, acc_c, ndone, pulses, md_pct;
        int idx [4];
        rst = 0;
        quiet();
        repeat (3) tick();
        #1 chk("reset_held", dut_vec(), 0);
        rst = 1;
        tick();
        #1 chk("after_release", dut_vec(), 0);

        // N=1, no stalls
        begin_block(1);
        for (int c = 1; c <= 8; c++) begin
            tick(); start = 0; mult_done = (c == 5); #1;
            chk($sformatf("n1_cycle%0d", c), pulse_vec(), t1[c]);
        end

        // N=3, two stall cycles in second LD_X
        begin_block(3);
        mult_done = 1; na = 0; done_c = -1;
        for (int c = 1; c <= 22; c++) begin
            tick(); start = 0; in_valid = !(c == 7 || c == 8); #1;
            if (acc_en) begin
                if (na < 4) idx[na] = term_idx;
                na++;
            end
            if (done) done_c = c;
        end
        chk("n3_acc_count", na, 3);
        chk("n3_idx0", idx[0], 0);
        chk("n3_idx1", idx[1], 1);
        chk("n3_idx2", idx[2], 2);
        chk("n3_done_cycle", done_c, 19);

        // N=0
        begin_block(0);
        done_c = -1; pulses = 0;
        for (int c = 1; c <= 3; c++) begin
            tick(); start = 0; #1;
            if (done) done_c = c;
            pulses += int'(acc_clr) + int'(ldu) + int'(ldd) + int'(mult_start);
        end
        chk("n0_done_cycle", done_c, 1);
        chk("n0_pulses", pulses, 0);

        // Timeout with mult_done held low
        begin_block(1);
        ndone = 0;
        for (int c = 1; c <= 21; c++) begin
            tick(); start = 0; #1;
            if (done) ndone++;
            if (c == 19) chk("to_busy_last_wait", busy, 1);
            if (c == 20) begin
                chk("to_err", err, 1);
                chk("to_busy", busy, 0);
            end
        end
        chk("to_no_done", ndone, 0);
        begin_block(1);
        mult_done = 1; #1;
        chk("to_err_before_start", err, 1);
        tick(); start = 0; #1;
        chk("to_err_cleared", err, 0);
        repeat (8) tick();

        // mult_done in WAIT cycle 15 wins over the timeout
        begin_block(1);
        acc_c = -1; done_c = -1;
        for (int c = 1; c <= 22; c++) begin
            tick(); start = 0; mult_done = (c == 19); #1;
            if (acc_en) acc_c = c;
            if (done) done_c = c;
            if (c == 21) chk("edge_err", err, 0);
        end
        chk("edge_acc_cycle", acc_c, 20);
        chk("edge_done_cycle", done_c, 21);

        // Abort in WAIT of pair 2 of N=4, with ignored start pulses
        begin_block(4);
        ndone = 0;
        for (int c = 1; c <= 14; c++) begin
            tick();
            start = (c == 3 || c == 8); n_terms = 0;
            mult_done = (c == 5); abort = (c == 10); #1;
            if (done) ndone++;
            if (c == 6) chk("ab_acc_first", acc_en, 1);
            if (c == 10) chk("ab_busy_in_wait", busy, 1);
            if (c == 11) begin
                chk("ab_idle", busy, 0);
                chk("ab_term_idx", term_idx, 1);
            end
        end
        chk("ab_no_done", ndone, 0);

        // Reset asserted mid-block
        begin_block(5);
        mult_done = 1;
        for (int c = 1; c <= 8; c++) begin
            tick(); start = 0;
        end
        #1 chk("rst_pre_idx", term_idx, 1);
        rst = 0;
        #1 chk("rst_immediate", dut_vec(), 0);
        tick(); tick();
        rst = 1;
        #1 chk("rst_released", dut_vec(), 0);

        // Randomized traffic
        md_pct = 30;
        for (int i = 0; i < 4000; i++) begin
            tick();
            if (!rst) rst = 1;
            if (i % 500 == 0) begin
                case ($urandom_range(0, 2))
                    0: md_pct = 3;
                    1: md_pct = 20;
                    default: md_pct = 60;
                endcase
            end
            start     = ($urandom_range(0, 7) == 0);
            n_terms   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                    : 4'($urandom_range(0, 3));
            in_valid  = ($urandom_range(0, 9) < 7);
            mult_done = ($urandom_range(0, 99) < md_pct);
            abort     = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 999) == 0) rst = 0;
        end
        tick();
        quiet();
        rst = 1;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mac_sequencer.md
# mac_sequencer

Control FSM for the gate-level MAC datapath. It accepts a block of N operand pairs from an 8-bit byte stream and steers the 16-bit operand register's upper/lower load strobes, the multiplier start/done handshake and the accumulator clear/enable. It reports completion with a one-cycle `done` pulse. It sits between the host/byte-stream source and the operand, multiplier and accumulator registers.

## Interface
Parameters:
- `TIMEOUT`, 15: max cycles spent in WAIT for `mult_done` before error (1..15).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `start`  in  1  begin a block; honoured only in IDLE.
- `n_terms`  in  4  number of operand pairs, sampled when `start` is accepted.
- `abort`  in  1  synchronous abort; returns to IDLE.
- `in_valid`  in  1  byte-stream source has a byte.
- `in_ready`  out  1  sequencer accepts a byte this cycle.
- `ldu`  out  1  load operand register [15:8] (X byte).
- `ldd`  out  1  load operand register [7:0] (Y byte).
- `mult_start`  out  1  one-cycle multiplier start pulse.
- `mult_done`  in  1  multiplier result valid.
- `acc_clr`  out  1  clear accumulator.
- `acc_en`  out  1  load accumulator with sum.
- `term_idx`  out  4  index of current pair, 0-based.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  sticky multiplier-timeout flag.

## Operation
- States: IDLE, CLR, LD_X, LD_Y, MUL, WAIT, ACC, DONE.
- IDLE: if `start`=1, latch `n_terms` into N and clear `err`. Go to DONE if N=0, else go to CLR.
- CLR: `acc_clr`=1 and `term_idx`←0, then go to LD_X.
- LD_X: `in_ready`=1. `ldu`=`in_valid`, combinational in the same cycle. On `in_valid` go to LD_Y, else stay.
- LD_Y: `in_ready`=1. `ldd`=`in_valid`. On `in_valid` go to MUL.
- MUL: `mult_start`=1 and timer←0, then go to WAIT.
- WAIT: on `mult_done` go to ACC. Otherwise the timer increments, and when timer=TIMEOUT-1 without `mult_done`, set `err`=1 and go to IDLE with no `done`. `mult_done` in the timeout cycle wins, so the FSM goes to ACC.
- ACC: `acc_en`=1. If `term_idx`+1=N go to DONE, else `term_idx`←`term_idx`+1 and go to LD_X.
- DONE: `done`=1, then go to IDLE.
- `abort`=1 in any non-IDLE state: next state is IDLE. No `done`, `err` unchanged, `term_idx` holds its value. `abort` has priority over all other transitions. `abort` in IDLE is ignored; `start` and `abort` together in IDLE means `abort` is ignored.
- `start` outside IDLE is ignored. `n_terms` changes after acceptance have no effect.
- `mult_done` outside WAIT is ignored.
- All outputs are Moore decodes of state, except `ldu` and `ldd`, which are state AND `in_valid`.
- `err` stays set until the next accepted `start`.

## Timing
- Reset (`rst`=0, asynchronous): state=IDLE, `term_idx`=0, timer=0, `err`=0, N=0. All outputs are 0 while reset is held and after release.
- Cycle numbering: `start` is sampled in cycle 0, and CLR is cycle 1.
- With zero stalls (`in_valid` always 1, `mult_done` in the first WAIT cycle), each pair takes 5 cycles: LD_X, LD_Y, MUL, WAIT, ACC.
- Pair k (1-based) occupies cycles 2+5(k-1) .. 6+5(k-1). DONE is in cycle 2+5N, and IDLE follows in cycle 3+5N.
- For N=0, `done` is in cycle 1 with no `acc_clr`.
- Each `in_valid` stall cycle and each extra WAIT cycle adds exactly one cycle.
- Back-to-back blocks: `start` may be accepted in the IDLE cycle right after DONE.
- Minimum WAIT dwell is 1 cycle. Timeout fires in WAIT cycle TIMEOUT, counting the first WAIT cycle as 1.

## Test plan
- Reset, then N=1 with `in_valid` held 1 and `mult_done` in the first WAIT cycle.
  - Cycle 1: `acc_clr`. Cycle 2: `ldu`. Cycle 3: `ldd`. Cycle 4: `mult_start`. Cycle 6: `acc_en`. Cycle 7: `done`.
  - `busy` is high in cycles 1–7; `err`=0.
- N=3 with `in_valid` low for 2 cycles in the second LD_X.
  - `term_idx` steps 0→1→2.
  - 3 `acc_en` pulses; `done` in cycle 19.
- N=0: `done` in cycle 1, with no `acc_clr`, `ldu`, `ldd` or `mult_start` pulses.
- Timeout with TIMEOUT=15 and `mult_done` held 0.
  - After 15 WAIT cycles: `err`=1, `busy`=0, no `done`.
  - On the next `start`, `err` returns to 0.
- Timeout boundary: `mult_done` asserted in WAIT cycle 15 → ACC, `err`=0.
- Abort in WAIT during pair 2 of N=4 → IDLE next cycle, no `done`.
  - `start` pulses during the block are ignored.
  - Asserting `rst` low mid-block clears all outputs immediately.
